// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one single-port SRAM (registered read, active-low strobes)
// between two REQ/ACK requesters. Each access costs a fixed 4 cycles:
// IDLE (grant) -> CMD (strobes low) -> WAIT (read data on the bus) -> ACK.
// Optional feature macro: SRAM_ARB_RR_EN selects round-robin arbitration;
// when undefined, port A has fixed priority over port B.
//
//   state | meaning
//   IDLE  | waiting for a request; on a request, latch the command and drive strobes
//   CMD   | command on the SRAM pins for this one cycle
//   WAIT  | SRAM registered read data valid on i_RAM_DOUT
//   ACK   | owner's ACK high for one cycle; REQ is not sampled here
module sram_arbiter #(
    parameter int DW = 8,
    parameter int AW = 10
) (
    input  logic          i_MCLK,
    input  logic          i_RST_n,
    input  logic          i_A_REQ,
    input  logic          i_A_WR,
    input  logic [AW-1:0] i_A_ADDR,
    input  logic [DW-1:0] i_A_DIN,
    output logic          o_A_ACK,
    output logic [DW-1:0] o_A_DOUT,
    input  logic          i_B_REQ,
    input  logic          i_B_WR,
    input  logic [AW-1:0] i_B_ADDR,
    input  logic [DW-1:0] i_B_DIN,
    output logic          o_B_ACK,
    output logic [DW-1:0] o_B_DOUT,
    output logic [AW-1:0] o_RAM_ADDR,
    output logic [DW-1:0] o_RAM_DIN,
    input  logic [DW-1:0] i_RAM_DOUT,
    output logic          o_RAM_CS_n,
    output logic          o_RAM_RD_n,
    output logic          o_RAM_WR_n
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_WAIT = 2'd2,
        ST_ACK  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          owner_b_q, owner_b_d;   // 1 = current access belongs to port B
    logic          is_rd_q, is_rd_d;       // current access is a read
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [DW-1:0] ram_din_q, ram_din_d;
    logic          cs_n_q, cs_n_d;
    logic          rd_n_q, rd_n_d;
    logic          wr_n_q, wr_n_d;
    logic          a_ack_q, a_ack_d;
    logic          b_ack_q, b_ack_d;
    logic [DW-1:0] a_dout_q, a_dout_d;
    logic [DW-1:0] b_dout_q, b_dout_d;
    logic          grant_b;
    logic          sel_wr;

`ifdef SRAM_ARB_RR_EN
    logic          last_b_q, last_b_d;     // 1 = B was granted most recently

    // Round-robin: on contention, grant the port not served last.
    always_comb grant_b = i_B_REQ && (!i_A_REQ || !last_b_q);
`else
    // Fixed priority: A always wins simultaneous requests.
    always_comb grant_b = i_B_REQ && !i_A_REQ;
`endif

    always_comb sel_wr = grant_b ? i_B_WR : i_A_WR;

    // Next-state and registered-output logic for the access sequence.
    always_comb begin
        state_d    = state_q;
        owner_b_d  = owner_b_q;
        is_rd_d    = is_rd_q;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        cs_n_d     = cs_n_q;
        rd_n_d     = rd_n_q;
        wr_n_d     = wr_n_q;
        a_ack_d    = a_ack_q;
        b_ack_d    = b_ack_q;
        a_dout_d   = a_dout_q;
        b_dout_d   = b_dout_q;
`ifdef SRAM_ARB_RR_EN
        last_b_d   = last_b_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (i_A_REQ || i_B_REQ) begin
                    owner_b_d  = grant_b;
                    is_rd_d    = !sel_wr;
                    ram_addr_d = grant_b ? i_B_ADDR : i_A_ADDR;
                    ram_din_d  = grant_b ? i_B_DIN : i_A_DIN;
                    cs_n_d     = 1'b0;
                    wr_n_d     = !sel_wr;
                    rd_n_d     = sel_wr;
`ifdef SRAM_ARB_RR_EN
                    last_b_d   = grant_b;
`endif
                    state_d    = ST_CMD;
                end
            end
            ST_CMD: begin
                cs_n_d  = 1'b1;
                rd_n_d  = 1'b1;
                wr_n_d  = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (is_rd_q) begin
                    if (owner_b_q) b_dout_d = i_RAM_DOUT;
                    else           a_dout_d = i_RAM_DOUT;
                end
                a_ack_d = !owner_b_q;
                b_ack_d = owner_b_q;
                state_d = ST_ACK;
            end
            ST_ACK: begin
                a_ack_d = 1'b0;
                b_ack_d = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset abandons any in-flight access silently.
    always_ff @(posedge i_MCLK) begin
        if (!i_RST_n) begin
            state_q    <= ST_IDLE;
            owner_b_q  <= 1'b0;
            is_rd_q    <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            cs_n_q     <= 1'b1;
            rd_n_q     <= 1'b1;
            wr_n_q     <= 1'b1;
            a_ack_q    <= 1'b0;
            b_ack_q    <= 1'b0;
            a_dout_q   <= '0;
            b_dout_q   <= '0;
`ifdef SRAM_ARB_RR_EN
            last_b_q   <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            owner_b_q  <= owner_b_d;
            is_rd_q    <= is_rd_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            cs_n_q     <= cs_n_d;
            rd_n_q     <= rd_n_d;
            wr_n_q     <= wr_n_d;
            a_ack_q    <= a_ack_d;
            b_ack_q    <= b_ack_d;
            a_dout_q   <= a_dout_d;
            b_dout_q   <= b_dout_d;
`ifdef SRAM_ARB_RR_EN
            last_b_q   <= last_b_d;
`endif
        end
    end

    assign o_A_ACK    = a_ack_q;
    assign o_B_ACK    = b_ack_q;
    assign o_A_DOUT   = a_dout_q;
    assign o_B_DOUT   = b_dout_q;
    assign o_RAM_ADDR = ram_addr_q;
    assign o_RAM_DIN  = ram_din_q;
    assign o_RAM_CS_n = cs_n_q;
    assign o_RAM_RD_n = rd_n_q;
    assign o_RAM_WR_n = wr_n_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural registered-read SRAM.
module tb_sram_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a_req = 1'b0, a_wr = 1'b0, b_req = 1'b0, b_wr = 1'b0;
    logic [9:0] a_addr = '0, b_addr = '0;
    logic [7:0] a_din = '0, b_din = '0;
    logic       a_ack, b_ack;
    logic [7:0] a_dout, b_dout;
    logic [9:0] ram_addr;
    logic [7:0] ram_din;
    logic [7:0] ram_dout = '0;
    logic       cs_n, rd_n, wr_n;

    logic [7:0] mem [0:1023];

    int n_tests = 0;
    int n_fail  = 0;
    int viol    = 0;
    int cs_lows = 0;
    logic prev_cs_low = 1'b0;

    always #5 clk = ~clk;

    sram_arbiter #(.DW(8), .AW(10)) dut (
        .i_MCLK(clk), .i_RST_n(rst_n),
        .i_A_REQ(a_req), .i_A_WR(a_wr), .i_A_ADDR(a_addr), .i_A_DIN(a_din),
        .o_A_ACK(a_ack), .o_A_DOUT(a_dout),
        .i_B_REQ(b_req), .i_B_WR(b_wr), .i_B_ADDR(b_addr), .i_B_DIN(b_din),
        .o_B_ACK(b_ack), .o_B_DOUT(b_dout),
        .o_RAM_ADDR(ram_addr), .o_RAM_DIN(ram_din), .i_RAM_DOUT(ram_dout),
        .o_RAM_CS_n(cs_n), .o_RAM_RD_n(rd_n), .o_RAM_WR_n(wr_n)
    );

    // Single-port SRAM: samples strobes on posedge, read data registered.
    always @(posedge clk) begin
        if (!cs_n) begin
            if (!wr_n) mem[ram_addr] <= ram_din;
            if (!rd_n) ram_dout <= mem[ram_addr];
        end
    end

    // Pin-protocol watcher: one strobe per access, CS low for single cycles only.
    always @(negedge clk) begin
        if (rst_n) begin
            if (!cs_n && (rd_n == wr_n)) viol++;
            if (cs_n && (!rd_n || !wr_n)) viol++;
            if (!cs_n && prev_cs_low) viol++;
            if (a_ack && b_ack) viol++;
            if (!cs_n) cs_lows++;
        end
        prev_cs_low = !cs_n;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full handshake on one port; ACK must arrive on the third edge after REQ.
    task automatic access(input logic port_b, input logic wr, input logic [9:0] addr,
                          input logic [7:0] din, input string tag);
        int n = 0;
        if (port_b) begin b_req = 1'b1; b_wr = wr; b_addr = addr; b_din = din; end
        else        begin a_req = 1'b1; a_wr = wr; a_addr = addr; a_din = din; end
        while (!(port_b ? b_ack : a_ack) && n < 10) begin
            tick();
            n++;
        end
        check({tag, " ack latency"}, n, 3);
        a_req = 1'b0;
        b_req = 1'b0;
        tick();
        check({tag, " ack one cycle"}, {31'd0, port_b ? b_ack : a_ack}, 0);
    endtask

    initial begin
        int a_cnt, b_cnt, first_a, first_b, cs_snap, ack_cnt;

        // reset values
        repeat (2) tick();
        check("rst cs_n", cs_n, 1);
        check("rst rd_n", rd_n, 1);
        check("rst wr_n", wr_n, 1);
        check("rst addr", ram_addr, 0);
        check("rst din", ram_din, 0);
        check("rst acks", {a_ack, b_ack}, 0);
        check("rst douts", {a_dout, b_dout}, 0);
        rst_n = 1'b1;
        tick();

        // A writes 0x5A to 0x123, pin-level timing
        a_req = 1'b1; a_wr = 1'b1; a_addr = 10'h123; a_din = 8'h5A;
        tick();
        check("wr cmd strobes", {cs_n, rd_n, wr_n}, 3'b010);
        check("wr cmd addr", ram_addr, 10'h123);
        check("wr cmd din", ram_din, 8'h5A);
        check("wr cmd ack", a_ack, 0);
        tick();
        check("wr wait strobes", {cs_n, rd_n, wr_n}, 3'b111);
        check("wr wait ack", a_ack, 0);
        tick();
        check("wr ack pulse", {a_ack, b_ack}, 2'b10);
        a_req = 1'b0;
        tick();
        check("wr ack clear", a_ack, 0);
        check("wr addr held", ram_addr, 10'h123);

        // A reads back
        access(1'b0, 1'b0, 10'h123, 8'h00, "rd A 123");
        check("rd A 123 dout", a_dout, 8'h5A);

        // isolation: A holds 0x11, B reads 0x3FF = 0xC3
        access(1'b0, 1'b1, 10'h040, 8'h11, "wr A 040");
        access(1'b0, 1'b0, 10'h040, 8'h00, "rd A 040");
        check("rd A 040 dout", a_dout, 8'h11);
        access(1'b1, 1'b1, 10'h3FF, 8'hC3, "wr B 3FF");
        check("wr B keeps B dout", b_dout, 8'h00);
        access(1'b1, 1'b0, 10'h3FF, 8'h00, "rd B 3FF");
        check("iso B dout", b_dout, 8'hC3);
        check("iso A dout", a_dout, 8'h11);

        // contention preload; B served last
        access(1'b0, 1'b1, 10'h010, 8'h77, "wr A 010");
        access(1'b1, 1'b1, 10'h020, 8'h88, "wr B 020");

        // both request reads continuously for 20 cycles
        a_req = 1'b1; a_wr = 1'b0; a_addr = 10'h010;
        b_req = 1'b1; b_wr = 1'b0; b_addr = 10'h020;
        a_cnt = 0; b_cnt = 0; first_a = 0; first_b = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (a_ack) begin a_cnt++; if (first_a == 0) first_a = i; end
            if (b_ack) begin b_cnt++; if (first_b == 0) first_b = i; end
        end
        a_req = 1'b0;
        b_req = 1'b0;
        tick();
        check("cont A dout", a_dout, 8'h77);
        check("cont first A ack", first_a, 3);
`ifdef SRAM_ARB_RR_EN
        check("rr A acks", a_cnt, 3);
        check("rr B acks", b_cnt, 2);
        check("rr first B ack", first_b, 7);
        check("rr B dout", b_dout, 8'h88);
`else
        check("fixed A acks", a_cnt, 5);
        check("fixed B acks", b_cnt, 0);
        check("fixed B dout", b_dout, 8'hC3);
`endif

        // reset during WAIT
        a_req = 1'b1; a_wr = 1'b0; a_addr = 10'h123;
        tick();
        tick();
        rst_n = 1'b0;
        a_req = 1'b0;
        tick();
        check("midrst ack", {a_ack, b_ack}, 0);
        check("midrst strobes", {cs_n, rd_n, wr_n}, 3'b111);
        check("midrst addr", ram_addr, 0);
        check("midrst din", ram_din, 0);
        check("midrst douts", {a_dout, b_dout}, 0);
        rst_n = 1'b1;
        tick();
        check("midrst no ack", a_ack, 0);
        access(1'b0, 1'b0, 10'h040, 8'h00, "post rst rd");
        check("post rst dout", a_dout, 8'h11);
        check("post rst mem kept", mem[10'h123], 8'h5A);

        // REQ dropped during CMD with the address changed
        a_req = 1'b1; a_wr = 1'b0; a_addr = 10'h3FF;
        tick();
        check("drop cmd strobes", {cs_n, rd_n, wr_n}, 3'b001);
        check("drop cmd addr", ram_addr, 10'h3FF);
        a_req = 1'b0; a_addr = 10'h000;
        tick();
        tick();
        check("drop ack", a_ack, 1);
        check("drop dout", a_dout, 8'hC3);
        cs_snap = cs_lows;
        ack_cnt = 0;
        repeat (8) begin
            tick();
            if (a_ack || b_ack) ack_cnt++;
        end
        check("drop no 2nd ack", ack_cnt, 0);
        check("drop no 2nd grant", cs_lows - cs_snap, 0);

        check("pin protocol", viol, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter that shares one single-port SRAM (registered read, posedge-sampled, active-low CS/RD/WR) between two requesters, e.g. the CPU bus and the video/sprite fetch engine. Each requester uses a REQ/ACK handshake. The arbiter grants one access at a time, drives the SRAM control pins for exactly one cycle, and returns read data to the granted port. It sits between the bus decoders and each SRAM instance.

## Interface
Parameters:
- `DW`, 8, data width.
- `AW`, 10, address width.

Ports:
- `i_MCLK`  in  1  master clock; all logic on posedge.
- `i_RST_n`  in  1  reset, synchronous, active-low.
- `i_A_REQ`  in  1  port A request.
- `i_A_WR`  in  1  port A direction: 1 = write, 0 = read.
- `i_A_ADDR`  in  AW  port A address.
- `i_A_DIN`  in  DW  port A write data.
- `o_A_ACK`  out  1  port A completion pulse, one cycle.
- `o_A_DOUT`  out  DW  port A read data.
- `i_B_*`, `o_B_*`: identical set for port B.
- `o_RAM_ADDR`  out  AW  SRAM address.
- `o_RAM_DIN`  out  DW  SRAM write data.
- `i_RAM_DOUT`  in  DW  SRAM registered read data.
- `o_RAM_CS_n`  out  1  SRAM chip select.
- `o_RAM_RD_n`  out  1  SRAM read strobe.
- `o_RAM_WR_n`  out  1  SRAM write strobe.

## Operation
- FSM states: IDLE, CMD, WAIT, ACK. All outputs are registered.
- **IDLE:** if any REQ is high, select a winner and latch its WR/ADDR/DIN into the SRAM output registers.
  - Drive `o_RAM_CS_n`=0 and either `o_RAM_WR_n`=0 (write) or `o_RAM_RD_n`=0 (read).
  - Record the grant owner. Go to CMD.
  - If no REQ is high, stay in IDLE.
- **CMD:** the command is on the SRAM pins for exactly this cycle. At the next edge, deassert CS_n/RD_n/WR_n to 1 and go to WAIT.
- **WAIT:** `i_RAM_DOUT` holds the read result.
  - At the next edge, for a read, load `i_RAM_DOUT` into the owner's `o_x_DOUT`. For a write, leave DOUT unchanged.
  - Set the owner's `o_x_ACK`=1. Go to ACK.
- **ACK:** the ACK is high for this one cycle. At the next edge clear ACK and go to IDLE.
  - REQ is not sampled in ACK. A registered requester has time to drop or renew REQ.
- **Handshake:**
  - The requester asserts REQ with a stable command and holds it until it sees ACK.
  - The command is latched at grant. Changes after grant, or REQ dropped early, do not affect the in-flight access. ACK is still issued.
- **Arbitration:** fixed priority, A over B (see Configuration). A loser keeps REQ high and is served on the next IDLE.
- `o_RAM_ADDR` and `o_RAM_DIN` hold their last values when idle. Only the strobes define an access.
- **Reset (`i_RST_n`=0 at any edge):**
  - State goes to IDLE and any in-flight access is abandoned, with no ACK. A write already sampled by the SRAM stays written.
  - Output reset values: `o_RAM_CS_n`=1, `o_RAM_RD_n`=1, `o_RAM_WR_n`=1, `o_RAM_ADDR`=0, `o_RAM_DIN`=0, `o_A_ACK`=`o_B_ACK`=0, `o_A_DOUT`=`o_B_DOUT`=0.
  - The round-robin pointer resets to "B last served".

## Timing
- REQ is sampled high at edge e0. The command is on the SRAM pins during [e0,e1] and the SRAM acts at e1.
- `i_RAM_DOUT` is valid during [e1,e2]. DOUT is captured at e2. ACK is high during [e2,e3].
- IDLE is re-entered at e3. The next REQ is sampled at e4.
- Fixed cost: 4 cycles per access. Peak throughput is one access every 4 cycles, whichever port.
- `o_x_DOUT` is valid from e2 and holds until that port's next read completes.
- Exactly one strobe is low per access. CS_n is never low outside CMD.

## Configuration
- **`SRAM_ARB_RR_EN` defined:** round-robin arbitration.
  - When both REQs are high in IDLE, grant the port not served last.
  - The pointer updates at each grant.
  - The first contention after reset goes to A.
- **Not defined:** fixed priority, A always wins simultaneous requests. B can starve under continuous A traffic.

## Test plan
- **Single write then read:**
  - A writes 0x5A to 0x123 → CS_n/WR_n low for one cycle with ADDR=0x123, DIN=0x5A, and `o_A_ACK` pulses 2 cycles after grant.
  - A reads 0x123 → `o_A_DOUT`=0x5A, valid with ACK.
- **Simultaneous requests, fixed priority:** A and B both request continuously → grants A,A,A…, and B receives no ACK.
- **Simultaneous requests, `SRAM_ARB_RR_EN`:** A reads 0x010 and B reads 0x020, both held → grants alternate A,B,A,B with ACKs 4 cycles apart, and each DOUT matches its own address's contents.
- **Isolation:** B reads 0x3FF (content 0xC3) while `o_A_DOUT`=0x11 → `o_A_DOUT` stays 0x11 and `o_B_DOUT`=0xC3.
- **Reset mid-access:** `i_RST_n`=0 during WAIT → no ACK, all outputs at reset values the next cycle, FSM in IDLE. A subsequent request completes normally in 4 cycles.
- **Early REQ drop:** A drops REQ in CMD → the access still completes with the latched address, ACK pulses once, and no second grant occurs.
